// File: rtl/program_sequencer.sv
// Instruction front end for the simple processor: issues a loaded 9-bit program over
// Run/DIN/Done, appends mvi immediates, and flags malformed programs or a missing Done.
module program_sequencer #(
  parameter int unsigned DEPTH   = 16,
  parameter logic [2:0]  MVI_OP  = 3'b011,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [8:0]               prog_wdata,
  input  logic [$clog2(DEPTH):0]   prog_len,
  input  logic                     start,
  input  logic                     Done,
  output logic [8:0]               DIN,
  output logic                     Run,
  output logic                     busy,
  output logic                     done_all,
  output logic                     error,
  output logic [7:0]               instr_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    IMM,
    WAIT_DONE,
    FINISH
  } state_e;

  state_e        state_q;
  logic [8:0]    mem_q [DEPTH];
  logic [LW-1:0] pc_q;
  logic [LW-1:0] len_q;
  logic [TW-1:0] tmo_q;
  logic          is_mvi_q;
  logic [8:0]    din_q;
  logic          run_q;
  logic          busy_q;
  logic          done_all_q;
  logic          error_q;
  logic [7:0]    count_q;

  logic [LW-1:0] pc_inc1_d;
  logic [LW-1:0] pc_inc2_d;
  logic [LW-1:0] pc_done_d;
  logic [8:0]    word_pc_d;
  logic [8:0]    word_imm_d;
  logic [8:0]    word_next_d;
  logic [8:0]    word_start_d;
  logic          cur_mvi_d;
  logic [7:0]    count_d;

  // Program store: writable only while idle, survives Reset.
  always_ff @(posedge Clock) begin
    if (!Reset && prog_we && state_q == IDLE) begin
      mem_q[prog_addr] <= prog_wdata;
    end
  end

  // Word fetch and pc arithmetic; the start word forwards a same-cycle write to address 0.
  always_comb begin
    pc_inc1_d    = pc_q + LW'(1);
    pc_inc2_d    = pc_q + LW'(2);
    pc_done_d    = is_mvi_q ? pc_inc2_d : pc_inc1_d;
    word_pc_d    = mem_q[pc_q[AW-1:0]];
    word_imm_d   = mem_q[pc_inc1_d[AW-1:0]];
    word_next_d  = mem_q[pc_done_d[AW-1:0]];
    word_start_d = (prog_we && prog_addr == '0) ? prog_wdata : mem_q[AW'(0)];
    cur_mvi_d    = (word_pc_d[8:6] == MVI_OP);
    count_d      = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
  end

  // Sequencer FSM; outputs are loaded on the edge that enters each state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      len_q      <= '0;
      tmo_q      <= '0;
      is_mvi_q   <= 1'b0;
      din_q      <= '0;
      run_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_all_q <= 1'b0;
      error_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      done_all_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          din_q  <= '0;
          run_q  <= 1'b0;
          busy_q <= 1'b0;
          if (start) begin
            len_q   <= prog_len;
            pc_q    <= '0;
            error_q <= 1'b0;
            count_q <= '0;
            busy_q  <= 1'b1;
            if (prog_len == '0) begin
              state_q    <= FINISH;
              done_all_q <= 1'b1;
            end else begin
              state_q <= ISSUE;
              din_q   <= word_start_d;
              run_q   <= 1'b1;
            end
          end
        end

        ISSUE: begin
          tmo_q    <= '0;
          is_mvi_q <= cur_mvi_d;
          if (cur_mvi_d) begin
            if (pc_inc1_d >= len_q) begin
              state_q <= IDLE;
              error_q <= 1'b1;
              din_q   <= '0;
              run_q   <= 1'b0;
              busy_q  <= 1'b0;
            end else begin
              state_q <= IMM;
              din_q   <= word_imm_d;
            end
          end else begin
            state_q <= WAIT_DONE;
          end
        end

        IMM, WAIT_DONE: begin
          if (Done) begin
            count_q <= count_d;
            pc_q    <= pc_done_d;
            if (pc_done_d >= len_q) begin
              state_q    <= FINISH;
              din_q      <= '0;
              run_q      <= 1'b0;
              done_all_q <= 1'b1;
            end else begin
              state_q <= ISSUE;
              din_q   <= word_next_d;
            end
          end else if (state_q == IMM) begin
            state_q <= WAIT_DONE;
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_q <= IDLE;
            error_q <= 1'b1;
            din_q   <= '0;
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end

        FINISH: begin
          state_q <= IDLE;
          din_q   <= '0;
          run_q   <= 1'b0;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
          din_q   <= '0;
          run_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign DIN         = din_q;
  assign Run         = run_q;
  assign busy        = busy_q;
  assign done_all    = done_all_q;
  assign error       = error_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: a processor model answers Run/DIN with Done,
// a program-level reference model predicts issued words, counts, outcome and latency.
module tb_program_sequencer;

  localparam int         TIMEOUT = 15;
  localparam logic [2:0] MVI     = 3'b011;
  localparam int M_NORM = 0;
  localparam int M_WE0  = 1;
  localparam int M_POKE = 2;
  localparam int M_RST  = 3;

  logic       Clock;
  logic       Reset;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [8:0] prog_wdata;
  logic [4:0] prog_len;
  logic       start;
  logic       Done = 1'b0;
  logic [8:0] DIN;
  logic       Run;
  logic       busy;
  logic       done_all;
  logic       error;
  logic [7:0] instr_count;

  program_sequencer dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_wdata  (prog_wdata),
    .prog_len    (prog_len),
    .start       (start),
    .Done        (Done),
    .DIN         (DIN),
    .Run         (Run),
    .busy        (busy),
    .done_all    (done_all),
    .error       (error),
    .instr_count (instr_count)
  );

  typedef struct {
    bit is_err;
    int count;
    int lat;
  } end_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         start_cyc = 0;
  int         ends_seen = 0;
  logic [8:0] mem_m [16];
  logic [8:0] exp_din [$];
  end_t       exp_end [$];
  int         dly_q [$];

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int dly_at(input int i);
    return (i < dly_q.size()) ? dly_q[i] : 2;
  endfunction

  // Program-level prediction: issued words, completed count, outcome and cycles from start.
  task automatic predict(input int len);
    int pc, t, cnt, di, d, lim;
    logic [8:0] w;
    bit mvi;
    end_t e;
    if (len == 0) begin
      e = '{1'b0, 0, 1};
      exp_end.push_back(e);
      return;
    end
    pc = 0; t = 1; cnt = 0; di = 0;
    forever begin
      w = mem_m[4'(pc)];
      exp_din.push_back(w);
      mvi = (w[8:6] == MVI);
      if (mvi && pc + 1 >= len) begin e = '{1'b1, cnt, t + 1}; break; end
      if (mvi) exp_din.push_back(mem_m[4'(pc + 1)]);
      d = dly_at(di);
      di++;
      lim = mvi ? TIMEOUT + 1 : TIMEOUT;
      if (d > lim) begin e = '{1'b1, cnt, t + lim + 1}; break; end
      cnt = (cnt == 255) ? 255 : cnt + 1;
      pc += mvi ? 2 : 1;
      if (pc >= len) begin e = '{1'b0, cnt, t + d + 1}; break; end
      t += d + 1;
    end
    exp_end.push_back(e);
  endtask

  task automatic capture(input logic [8:0] w);
    if (exp_din.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_issue: got DIN %0h expected no issue (cycle %0d)", w, cyc);
    end else begin
      check("din_word", 32'(w), 32'(exp_din.pop_front()));
    end
  endtask

  // Processor model: latch instruction (and immediate), raise Done d cycles after ISSUE.
  initial begin : processor
    int ph;
    int pcnt;
    ph = 0;
    pcnt = 0;
    forever begin
      @(negedge Clock);
      Done = 1'b0;
      if (Run !== 1'b1) begin
        ph = 0;
      end else begin
        case (ph)
          0: begin
            capture(DIN);
            if (dly_q.size() > 0) pcnt = dly_q.pop_front();
            else pcnt = 2;
            ph = (DIN[8:6] == MVI) ? 1 : 2;
          end
          1: begin
            capture(DIN);
            pcnt--;
            if (pcnt == 0) begin Done = 1'b1; ph = 0; end
            else ph = 2;
          end
          default: begin
            pcnt--;
            if (pcnt == 0) begin Done = 1'b1; ph = 0; end
          end
        endcase
      end
    end
  end

  // End-of-run monitor: pops the predicted outcome on done_all or a rising error.
  initial begin : monitor
    bit   err_prev;
    end_t e;
    err_prev = 1'b0;
    forever begin
      @(negedge Clock);
      if (done_all === 1'b1 || (error === 1'b1 && !err_prev)) begin
        ends_seen++;
        if (exp_end.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_end: got done_all=%0b error=%0b expected none (cycle %0d)",
                   done_all, error, cyc);
        end else begin
          e = exp_end.pop_front();
          check("end_error", 32'(error), 32'(e.is_err));
          check("end_done_all", 32'(done_all), 32'(!e.is_err));
          check("end_latency", 32'(cyc - start_cyc), 32'(e.lat));
          check("end_count", 32'(instr_count), 32'(e.count));
          check("end_run", 32'(Run), 0);
          check("end_busy", 32'(busy), 32'(!e.is_err));
          if (!e.is_err) check("end_din", 32'(DIN), 0);
        end
      end
      err_prev = (error === 1'b1);
    end
  end

  task automatic load_all();
    for (int i = 0; i < 16; i++) begin
      @(negedge Clock);
      prog_we    = 1'b1;
      prog_addr  = 4'(i);
      prog_wdata = mem_m[i];
    end
    @(negedge Clock);
    prog_we = 1'b0;
  endtask

  task automatic set_dly(input int d, input int n);
    dly_q.delete();
    for (int i = 0; i < n; i++) dly_q.push_back(d);
  endtask

  task automatic wait_end(input int target);
    int k;
    k = 0;
    while (ends_seen < target && k < 400) begin
      @(negedge Clock);
      k++;
    end
    if (ends_seen < target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL end_timeout: got no done_all/error expected one within 400 cycles (cycle %0d)", cyc);
    end
  endtask

  task automatic run_prog(input int len, input int mode, input logic [8:0] w0);
    int target;
    if (mode == M_WE0) mem_m[0] = w0;
    target = ends_seen + 1;
    predict(len);
    @(negedge Clock);
    prog_len  = 5'(len);
    start     = 1'b1;
    start_cyc = cyc;
    if (mode == M_WE0) begin
      prog_we = 1'b1; prog_addr = '0; prog_wdata = w0;
    end
    @(negedge Clock);
    start = 1'b0;
    prog_we = 1'b0;
    if (mode == M_POKE) begin
      @(negedge Clock);
      start = 1'b1; prog_len = '0; prog_we = 1'b1; prog_addr = '0; prog_wdata = 9'h1FF;
      @(negedge Clock);
      start = 1'b0; prog_we = 1'b0;
    end
    if (mode == M_RST) begin
      repeat (3) @(negedge Clock);
      Reset = 1'b1;
      @(negedge Clock);
      check("rst_run", 32'(Run), 0);
      check("rst_din", 32'(DIN), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_count", 32'(instr_count), 0);
      Reset = 1'b0;
      exp_din.delete();
      exp_end.delete();
      dly_q.delete();
    end else begin
      wait_end(target);
      check("din_drained", 32'(exp_din.size()), 0);
      @(negedge Clock);
      check("idle_busy", 32'(busy), 0);
      check("idle_run", 32'(Run), 0);
    end
  endtask

  initial begin : stimulus
    Reset = 1'b1; start = 1'b0; prog_we = 1'b0;
    prog_addr = '0; prog_wdata = '0; prog_len = '0;
    repeat (2) @(negedge Clock);
    check("reset_din", 32'(DIN), 0);
    check("reset_run", 32'(Run), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done_all", 32'(done_all), 0);
    check("reset_error", 32'(error), 0);
    check("reset_count", 32'(instr_count), 0);
    Reset = 1'b0;

    for (int i = 0; i < 16; i++) mem_m[i] = 9'h000;
    mem_m[0] = 9'h0C1; mem_m[1] = 9'h1F0; mem_m[2] = 9'h0D1;
    mem_m[3] = 9'h10F; mem_m[4] = 9'h082;
    load_all();
    set_dly(2, 8); run_prog(5, M_NORM, '0);
    set_dly(2, 8); run_prog(5, M_POKE, '0);
    set_dly(2, 8); run_prog(5, M_NORM, '0);

    mem_m[0] = 9'h0C9; load_all();
    set_dly(2, 4); run_prog(1, M_NORM, '0);
    run_prog(0, M_NORM, '0);

    mem_m[0] = 9'h10F; load_all();
    set_dly(100, 4); run_prog(3, M_NORM, '0);
    set_dly(100, 4); run_prog(3, M_RST, '0);
    dly_q.delete(); dly_q.push_back(1); dly_q.push_back(3); dly_q.push_back(2);
    run_prog(3, M_NORM, '0);
    set_dly(1, 8); run_prog(4, M_WE0, 9'h0D1);

    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 16; i++) begin
        mem_m[i] = 9'($urandom);
        if ($urandom_range(0, 2) == 0) mem_m[i][8:6] = MVI;
      end
      load_all();
      dly_q.delete();
      for (int i = 0; i < 20; i++) begin
        if ($urandom_range(0, 9) < 9) dly_q.push_back(int'($urandom_range(1, 4)));
        else dly_q.push_back(int'($urandom_range(13, 17)));
      end
      run_prog(int'($urandom_range(0, 16)), ($urandom_range(0, 3) == 0) ? M_WE0 : M_NORM,
               9'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge Clock);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Instruction-issuing front end for simple_processor_Top; performs the initiator role toward the processor's Run/DIN/Done interface.
- Holds a small loadable program memory of 9-bit words and issues them in order on DIN.
- Supplies the immediate word after every mvi instruction and waits for the processor's Done before advancing.
- Reports completion, instruction count and timeout error to the system or bench.

Parameters:
- DEPTH, 16: program memory words; address width is clog2(DEPTH).
- MVI_OP, 3'b011: opcode in DIN[8:6] that is followed by one immediate word.
- TIMEOUT, 15: maximum cycles to wait for Done per instruction before error.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- prog_we  in  1  program memory write enable.
- prog_addr  in  clog2(DEPTH)  write address.
- prog_wdata  in  9  write data.
- prog_len  in  clog2(DEPTH)+1  number of valid words; sampled on start.
- start  in  1  begin execution at word 0.
- Done  in  1  processor completion pulse.
- DIN  out  9  word presented to the processor.
- Run  out  1  processor run request.
- busy  out  1  high when the state is not IDLE.
- done_all  out  1  one-cycle pulse when the program completes.
- error  out  1  sticky error flag; cleared by Reset or by an accepted start.
- instr_count  out  8  instructions completed since the last accepted start; saturates at 255.

Behaviour:
- Reset values: DIN=0, Run=0, busy=0, done_all=0, error=0, instr_count=0, pc=0, state=IDLE.
- Program memory is not cleared by Reset.
- Memory writes:
  - Accepted only when the state is IDLE and prog_we=1; ignored otherwise.
  - Memory read is combinational from the register array.
- States: IDLE, ISSUE, IMM, WAIT_DONE, FINISH.
- IDLE:
  - Outputs DIN=0, Run=0.
  - On start=1: latch len=prog_len, set pc=0, clear error and instr_count.
  - If len=0, go to FINISH; otherwise go to ISSUE.
- ISSUE (exactly one cycle):
  - DIN=mem[pc], Run=1; the timeout counter is cleared.
  - If mem[pc][8:6]==MVI_OP: if pc+1>=len (malformed program), set error and go to IDLE; otherwise go to IMM.
  - Otherwise go to WAIT_DONE.
  - Done is ignored in this cycle.
- IMM (one cycle):
  - DIN=mem[pc+1], Run=1.
  - If Done=1, the instruction completes in this cycle: pc+=2 and apply the completion rule below.
  - Otherwise go to WAIT_DONE with DIN held at the immediate.
- WAIT_DONE:
  - Run=1; DIN holds its last value; the timeout counter increments each cycle.
  - On Done=1: pc += 2 if the instruction was mvi, otherwise pc += 1; apply the completion rule.
  - If the counter reaches TIMEOUT without Done: set error, Run=0, go to IDLE.
- Completion rule (on every Done):
  - instr_count increments.
  - If the new pc>=len, go to FINISH; otherwise go to ISSUE on the next cycle.
- FINISH (one cycle): done_all=1, Run=0, DIN=0; next state IDLE.
- Simultaneous events:
  - start while busy is ignored.
  - Done while IDLE or FINISH is ignored.
  - start and prog_we together in IDLE: the write completes and start is accepted in the same cycle. Execution uses the new word because ISSUE is one cycle later.
- Reset mid-operation: Reset has priority over all inputs; all outputs drop to their reset values on the next edge.
- Latency:
  - start to first ISSUE: 1 cycle.
  - Done to the next ISSUE: 1 cycle.
  - Final Done to done_all: 1 cycle.

Test Plan:
- Load [011_000_001, 111_110_000, 011_010_001, 100_001_111, 010_000_010], len=5; processor model asserts Done 2 cycles after each ISSUE. Required: DIN sequence issued in that order; 3 instructions executed; instr_count=3; done_all pulses once; error=0.
- Model holds Done low after the first ISSUE. Required: error=1 exactly TIMEOUT cycles after ISSUE exits; Run=0; state returns to IDLE.
- Load len=1 with word 011_001_001 (mvi with no immediate). Required: error=1 one cycle after ISSUE; Done is never awaited.
- Start with len=0. Required: done_all pulses 1 cycle after start; Run stays 0.
- Assert Reset in the middle of WAIT_DONE. Required: next cycle Run=0, DIN=0, busy=0. A following start re-runs from word 0 with the memory intact.
- Pulse prog_we while busy with addr=0, data=9'h1FF; then a second start. Required: memory word 0 is unchanged and the second start is ignored while busy.
